tail_input_conditioner: RTL
===========================

Name: tail_input_conditioner

Overview:
Front-end stage that feeds the tail-light state controller and output wrapper.
- Synchronises and debounces the five raw dash switches (left, right, brake, hazard, run).
- Generates the one-cycle sequencing strobe (step_en) that advances the light-pattern state machine.
- Generates the dimclk PWM waveform used for running-light dimming.
- All logic is on one clock. There are no combinational paths from inputs to outputs.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive synchronised cycles a new level must hold before the debounced output changes. Must be ≥1.
- BLINK_DIV, 12500000: clk cycles per step_en strobe. Must be ≥2. The default gives 4 Hz at 50 MHz.
- DIM_PERIOD, 8: dimclk PWM period in clk cycles. Must be ≥1.
- DIM_DUTY, 1: number of high cycles of dimclk per period. Range 0..DIM_PERIOD.

Ports:
- clk  in  1  system clock; all flops clock on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- left_raw  in  1  raw left-turn switch, asynchronous to clk.
- right_raw  in  1  raw right-turn switch, asynchronous to clk.
- brake_raw  in  1  raw brake switch, asynchronous to clk.
- hazard_raw  in  1  raw hazard switch, asynchronous to clk.
- run_raw  in  1  raw running-light switch, asynchronous to clk.
- left  out  1  debounced left.
- right  out  1  debounced right.
- brake  out  1  debounced brake.
- hazard  out  1  debounced hazard.
- run  out  1  debounced run.
- step_en  out  1  one-cycle sequencing strobe.
- dimclk  out  1  PWM dim waveform.

Behaviour:
- Reset: rst low forces all sync flops, debounce counters, blink counter and dim counter to 0 immediately, without waiting for clk. All outputs read 0 during reset.
- Reset may assert mid-debounce or mid-period. All partial counts are discarded. There is no reset-release sequencing beyond the ordinary synchronous count restart.
- Synchroniser: each raw input passes through a 2-flop synchroniser. Call its output s.
- Debounce (independent per channel; D = DEBOUNCE_CYCLES):
  - If s equals the current debounced output: counter is cleared to 0.
  - Else, if counter = D-1: the debounced output takes the value of s and the counter clears.
  - Else: counter increments.
  - Latency: the debounced output changes D+1 edges after the edge that first samples the new raw level into sync stage 1.
  - A raw pulse whose s-level lasts fewer than D cycles produces no output change.
  - Counter width is clog2(D), minimum 1 bit.
- Blink divider:
  - Counter runs 0..BLINK_DIV-1 and wraps to 0.
  - step_en is registered. It is 1 for exactly the one cycle after the counter equals BLINK_DIV-1, so there is one strobe every BLINK_DIV cycles.
  - Restart: on any cycle where debounced left, right or hazard rises 0→1, the counter is forced to 0 and step_en is forced to 0 on the next cycle.
  - After a restart, the first strobe appears BLINK_DIV cycles after the restart. Falling edges and brake/run edges do not restart.
  - Simultaneous rises on several channels cause a single restart.
  - A restart that coincides with the terminal count wins: no strobe is produced.
- Dim PWM:
  - Free-running counter 0..DIM_PERIOD-1. It is never restarted except by reset.
  - dimclk is registered as (counter < DIM_DUTY).
  - DIM_DUTY=0 gives dimclk stuck at 0. DIM_DUTY=DIM_PERIOD gives dimclk stuck at 1 after the first edge out of reset.
- Outputs hold their values between updates. There is no handshake; consumers sample on clk.

Test Plan:
- Reset: rst=0 mid-operation with all raw inputs at 1 → all outputs 0 immediately, asynchronously. After release, with DEBOUNCE_CYCLES=4, all five debounced outputs read 1 after the 5th edge.
- Debounce latency (DEBOUNCE_CYCLES=4): brake_raw 0→1 sampled at edge 0 → brake=1 after edge 5. Release → brake=0 after a further 5 edges.
- Glitch rejection (DEBOUNCE_CYCLES=4): left_raw high for 3 cycles then low → left stays 0 throughout. A second pulse of 4 cycles → left=1.
- Strobe period (BLINK_DIV=5, inputs idle) → step_en high on cycles 5, 10, 15… after reset, each exactly one cycle wide.
- Restart (BLINK_DIV=5): debounced right rises on the cycle where a strobe was due → no strobe that cycle, next strobe 5 cycles later. right falling → cadence unchanged.
- PWM: DIM_PERIOD=8, DIM_DUTY=1 → dimclk high 1 of every 8 cycles. DIM_DUTY=0 → always 0. DIM_DUTY=8 → always 1 after the first edge.

Source files
------------

// File: rtl/tail_input_conditioner_if.sv
// Dash-switch bundle between the raw switch inputs and the conditioned outputs that
// feed the tail-light controller.
interface tail_input_conditioner_if;
  logic left_raw;
  logic right_raw;
  logic brake_raw;
  logic hazard_raw;
  logic run_raw;
  logic left;
  logic right;
  logic brake;
  logic hazard;
  logic run;
  logic step_en;
  logic dimclk;

  modport master (
    output left_raw, right_raw, brake_raw, hazard_raw, run_raw,
    input  left, right, brake, hazard, run, step_en, dimclk
  );

  modport slave (
    input  left_raw, right_raw, brake_raw, hazard_raw, run_raw,
    output left, right, brake, hazard, run, step_en, dimclk
  );
endinterface

// File: rtl/tail_input_conditioner.sv
// Tail-light front end: 2-flop sync and debounce of five dash switches, blink-step
// strobe generator with restart on turn/hazard activation, and dimclk PWM.
module tail_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned BLINK_DIV       = 12500000,
  parameter int unsigned DIM_PERIOD      = 8,
  parameter int unsigned DIM_DUTY        = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  tail_input_conditioner_if.slave   bus
);

  localparam int unsigned NumCh  = 5;
  localparam int unsigned DebW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned BlinkW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam int unsigned DimW   = (DIM_PERIOD > 1) ? $clog2(DIM_PERIOD) : 1;

  localparam logic [DebW-1:0]   DebLast   = DebW'(DEBOUNCE_CYCLES - 1);
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_DIV - 1);
  localparam logic [DimW-1:0]   DimLast   = DimW'(DIM_PERIOD - 1);
  localparam logic [DimW:0]     DutyCmp   = (DimW + 1)'(DIM_DUTY);
  // Channel order {run, hazard, brake, right, left}; only left/right/hazard restart blink.
  localparam logic [NumCh-1:0]  DirMask   = 5'b01011;

  logic [NumCh-1:0]  w_raw;
  logic [NumCh-1:0]  r_sync1;
  logic [NumCh-1:0]  r_sync2;
  logic [NumCh-1:0]  r_db;
  logic [NumCh-1:0]  w_db_d;
  logic [DebW-1:0]   r_deb_cnt [NumCh];
  logic [DebW-1:0]   w_deb_cnt_d [NumCh];
  logic              w_restart;
  logic [BlinkW-1:0] r_blink_cnt;
  logic [BlinkW-1:0] w_blink_cnt_d;
  logic              r_step;
  logic              w_step_d;
  logic [DimW-1:0]   r_dim_cnt;
  logic [DimW-1:0]   w_dim_cnt_d;
  logic              r_dimclk;
  logic              w_dim_on;

  assign w_raw = {bus.run_raw, bus.hazard_raw, bus.brake_raw, bus.right_raw, bus.left_raw};

  always_comb begin
    w_db_d = r_db;
    for (int ch = 0; ch < NumCh; ch++) begin
      w_deb_cnt_d[ch] = '0;
      if (r_sync2[ch] != r_db[ch]) begin
        if (r_deb_cnt[ch] == DebLast) begin
          w_db_d[ch] = r_sync2[ch];
        end else begin
          w_deb_cnt_d[ch] = r_deb_cnt[ch] + 1'b1;
        end
      end
    end
  end

  // Restart keys off the debounced next-state so it lands on the same edge the output rises.
  assign w_restart = |(w_db_d & ~r_db & DirMask);

  always_comb begin
    w_blink_cnt_d = r_blink_cnt + 1'b1;
    w_step_d      = 1'b0;
    if (w_restart) begin
      w_blink_cnt_d = '0;
    end else if (r_blink_cnt == BlinkLast) begin
      w_blink_cnt_d = '0;
      w_step_d      = 1'b1;
    end
  end

  assign w_dim_cnt_d = (r_dim_cnt == DimLast) ? '0 : r_dim_cnt + 1'b1;

  generate
    if (DIM_DUTY == 0) begin : g_dim_off
      assign w_dim_on = 1'b0;
    end else begin : g_dim_cmp
      assign w_dim_on = ({1'b0, r_dim_cnt} < DutyCmp);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1     <= '0;
      r_sync2     <= '0;
      r_db        <= '0;
      for (int ch = 0; ch < NumCh; ch++) begin
        r_deb_cnt[ch] <= '0;
      end
      r_blink_cnt <= '0;
      r_step      <= 1'b0;
      r_dim_cnt   <= '0;
      r_dimclk    <= 1'b0;
    end else begin
      r_sync1     <= w_raw;
      r_sync2     <= r_sync1;
      r_db        <= w_db_d;
      for (int ch = 0; ch < NumCh; ch++) begin
        r_deb_cnt[ch] <= w_deb_cnt_d[ch];
      end
      r_blink_cnt <= w_blink_cnt_d;
      r_step      <= w_step_d;
      r_dim_cnt   <= w_dim_cnt_d;
      r_dimclk    <= w_dim_on;
    end
  end

  assign bus.left    = r_db[0];
  assign bus.right   = r_db[1];
  assign bus.brake   = r_db[2];
  assign bus.hazard  = r_db[3];
  assign bus.run     = r_db[4];
  assign bus.step_en = r_step;
  assign bus.dimclk  = r_dimclk;

endmodule
